approx_err_monitor: RTL and testbench

//  Downstream QoR stage for an approximated multiplier partition (11-in/13-out BMF netlist).

---
 rtl/approx_err_monitor_if.sv | 37 +++
 rtl/approx_err_monitor.sv | 224 ++++++++++++++++++++++
 tb/tb_approx_err_monitor.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_err_monitor_if.sv
// -----------------------------------------------------------------------------
// approx_err_monitor_if
// Sample-pair stream carrying one approximate word and its exact reference
// word into the error monitor.
//
// Signals:
//   in_valid  producer -> monitor   sample pair valid
//   in_ready  monitor  -> producer  monitor accepts a pair this cycle
//   approx    producer -> monitor   approximate partition output word (W bits)
//   exact     producer -> monitor   exact reference output word (W bits)
//
// Modports:
//   master  producer side (eval harness / testbench)
//   slave   monitor side
// -----------------------------------------------------------------------------
interface approx_err_monitor_if #(
    parameter int W = 13
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] approx;
    logic [W-1:0] exact;

    modport master (
        output in_valid,
        output approx,
        output exact,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  approx,
        input  exact,
        output in_ready
    );
endinterface

// File: rtl/approx_err_monitor.sv
// -----------------------------------------------------------------------------
// approx_err_monitor
// QoR stage for an approximated multiplier partition. For every accepted
// (approx, exact) pair it accumulates, over a fixed run of N_SAMPLES pairs:
//   err_cnt  number of pairs with approx != exact
//   sad      saturating sum of |approx - exact|
//   max_ed   largest |approx - exact| seen
//   sq_sum   saturating sum of (approx - exact)^2 (only with SQERR_EN)
//
// Optional feature macro:
//   SQERR_EN  defined   -> squared-error accumulator present
//             undefined -> no multiplier/register, sq_sum tied to 0
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   pulse; clears stats and starts a run (IDLE/DONE only)
//   in_bus   slave modport of approx_err_monitor_if (in_valid/in_ready/approx/exact)
//   busy     out  high in RUN or DRAIN
//   done     out  high in DONE; stats final and stable
//   err_cnt  out  mismatch count
//   sad      out  sum of absolute error (saturating)
//   max_ed   out  maximum absolute error
//   sq_sum   out  sum of squared error (saturating)
//
// Latency: a pair accepted on edge t is captured on t, its |error| is
// registered on t+1 and folded into the stats on t+2. DRAIN lasts two
// cycles, so done rises on the same edge the last pair retires.
// -----------------------------------------------------------------------------
module approx_err_monitor #(
    parameter int W         = 13,
    parameter int N_SAMPLES = 2048,
    parameter int CNT_W     = 16,
    parameter int SUM_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    approx_err_monitor_if.slave      in_bus,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [SUM_W-1:0]         sad,
    output logic [W-1:0]             max_ed,
    output logic [SUM_W-1:0]         sq_sum
);

    localparam int SMP_W = $clog2(N_SAMPLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // ---------------------------------------------------------------- control
    state_t             state_q;
    logic               in_ready_q;
    logic               busy_q;
    logic               done_q;
    logic               drain_q;
    logic [SMP_W-1:0]   smp_cnt_q;

    logic accept;
    logic run_start;

    // in_ready comes straight from a register, so there is no path from
    // in_valid back to in_ready.
    assign accept    = in_bus.in_valid & in_ready_q;
    assign run_start = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            drain_q    <= 1'b0;
            smp_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (run_start) begin
                        state_q    <= ST_RUN;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        smp_cnt_q  <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        smp_cnt_q <= smp_cnt_q + 1'b1;
                        if (smp_cnt_q == SMP_W'(N_SAMPLES - 1)) begin
                            state_q    <= ST_DRAIN;
                            in_ready_q <= 1'b0;
                            drain_q    <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Two cycles: enough for the last pair to pass both stages.
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_bus.in_ready = in_ready_q;
    assign busy            = busy_q;
    assign done            = done_q;

    // --------------------------------------------------------------- pipeline
    // Capture register for the accepted pair.
    logic         s0_vld_q;
    logic [W-1:0] s0_ap_q;
    logic [W-1:0] s0_ex_q;

    // S1: absolute error and mismatch flag.
    logic         s1_vld_q;
    logic         s1_neq_q;
    logic [W-1:0] s1_ed_q;

    logic signed [W:0] diff_s;
    logic [W-1:0]      ed_abs;

    // One extra bit keeps the difference exact; magnitude always fits in W.
    assign diff_s = $signed({1'b0, s0_ap_q}) - $signed({1'b0, s0_ex_q});
    assign ed_abs = diff_s[W] ? W'(-diff_s) : diff_s[W-1:0];

    always_ff @(posedge clk) begin
        if (rst || run_start) begin
            s0_vld_q <= 1'b0;
            s0_ap_q  <= '0;
            s0_ex_q  <= '0;
            s1_vld_q <= 1'b0;
            s1_neq_q <= 1'b0;
            s1_ed_q  <= '0;
        end else begin
            s0_vld_q <= accept;
            if (accept) begin
                s0_ap_q <= in_bus.approx;
                s0_ex_q <= in_bus.exact;
            end
            s1_vld_q <= s0_vld_q;
            s1_neq_q <= s0_vld_q & (s0_ap_q != s0_ex_q);
            s1_ed_q  <= s0_vld_q ? ed_abs : '0;
        end
    end

    // ----------------------------------------------------------- S2: stats
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [SUM_W-1:0] sad_q,     sad_d;
    logic [W-1:0]     max_ed_q,  max_ed_d;
    logic [SUM_W:0]   sad_sum;

    assign sad_sum = {1'b0, sad_q} + {{(SUM_W + 1 - W){1'b0}}, s1_ed_q};

    always_comb begin
        err_cnt_d = err_cnt_q + CNT_W'(s1_neq_q);
        // Carry out of the widened sum means the clamp value is reached.
        sad_d     = sad_sum[SUM_W] ? {SUM_W{1'b1}} : sad_sum[SUM_W-1:0];
        max_ed_d  = (s1_ed_q > max_ed_q) ? s1_ed_q : max_ed_q;
    end

    always_ff @(posedge clk) begin
        if (rst || run_start) begin
            err_cnt_q <= '0;
            sad_q     <= '0;
            max_ed_q  <= '0;
        end else if (s1_vld_q) begin
            err_cnt_q <= err_cnt_d;
            sad_q     <= sad_d;
            max_ed_q  <= max_ed_d;
        end
    end

    assign err_cnt = err_cnt_q;
    assign sad     = sad_q;
    assign max_ed  = max_ed_q;

`ifdef SQERR_EN
    // Squared error: the product is zero-extended or clamped to SUM_W by
    // doing the add in a width that holds both operands, then clamping.
    localparam int SQ_W = (2 * W > SUM_W) ? 2 * W : SUM_W;
    localparam logic [SQ_W:0] SQ_LIM = (SQ_W + 1)'({SUM_W{1'b1}});

    logic [SUM_W-1:0] sq_sum_q, sq_sum_d;
    logic [2*W-1:0]   sq_prod;
    logic [SQ_W:0]    sq_full;

    assign sq_prod = s1_ed_q * s1_ed_q;
    assign sq_full = (SQ_W + 1)'(sq_sum_q) + (SQ_W + 1)'(sq_prod);

    always_comb begin
        sq_sum_d = (sq_full > SQ_LIM) ? {SUM_W{1'b1}} : sq_full[SUM_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst || run_start) begin
            sq_sum_q <= '0;
        end else if (s1_vld_q) begin
            sq_sum_q <= sq_sum_d;
        end
    end

    assign sq_sum = sq_sum_q;
`else
    assign sq_sum = '0;
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
// -----------------------------------------------------------------------------
// tb_approx_err_monitor
// Two monitor instances share clk/rst:
//   A: default configuration (N_SAMPLES=2048, SUM_W=32)
//   B: short runs with a narrow accumulator (N_SAMPLES=4, SUM_W=14)
// Expected statistics come from a reference model that works on the list of
// pairs handed to each run with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_approx_err_monitor;

    localparam int W     = 13;
    localparam int NA    = 2048;
    localparam int NB    = 4;
    localparam int SUMWA = 32;
    localparam int SUMWB = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_start = 1'b0;
    logic b_start = 1'b0;

    logic              a_busy, a_done, b_busy, b_done;
    logic [15:0]       a_err, b_err;
    logic [SUMWA-1:0]  a_sad, a_sq;
    logic [SUMWB-1:0]  b_sad, b_sq;
    logic [W-1:0]      a_max, b_max;

    approx_err_monitor_if #(.W(W)) ia ();
    approx_err_monitor_if #(.W(W)) ib ();

    always #5 clk = ~clk;

    approx_err_monitor #(.W(W), .N_SAMPLES(NA), .CNT_W(16), .SUM_W(SUMWA)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .in_bus(ia),
        .busy(a_busy), .done(a_done), .err_cnt(a_err), .sad(a_sad),
        .max_ed(a_max), .sq_sum(a_sq)
    );

    approx_err_monitor #(.W(W), .N_SAMPLES(NB), .CNT_W(16), .SUM_W(SUMWB)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .in_bus(ib),
        .busy(b_busy), .done(b_done), .err_cnt(b_err), .sad(b_sad),
        .max_ed(b_max), .sq_sum(b_sq)
    );

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [W-1:0] stim_ap[$];
    logic [W-1:0] stim_ex[$];

    longint exp_cnt, exp_sad, exp_max, exp_sq;

    task automatic check(input string tag, input longint o, input longint e);
        total_cnt++;
        assert (o === e) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    function automatic logic [W-1:0] r13();
        return W'($urandom_range(8191));
    endfunction

    // what: 0 ready, 1 busy, 2 done, 3 err_cnt, 4 sad, 5 max_ed, 6 sq_sum
    function automatic longint obs(input int sel, input int what);
        longint v;
        v = 0;
        if (sel == 0) begin
            case (what)
                0: v = longint'(ia.in_ready);
                1: v = longint'(a_busy);
                2: v = longint'(a_done);
                3: v = longint'(a_err);
                4: v = longint'(a_sad);
                5: v = longint'(a_max);
                default: v = longint'(a_sq);
            endcase
        end else begin
            case (what)
                0: v = longint'(ib.in_ready);
                1: v = longint'(b_busy);
                2: v = longint'(b_done);
                3: v = longint'(b_err);
                4: v = longint'(b_sad);
                5: v = longint'(b_max);
                default: v = longint'(b_sq);
            endcase
        end
        return v;
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [W-1:0] ap, input logic [W-1:0] ex);
        if (sel == 0) begin
            ia.in_valid = v; ia.approx = ap; ia.exact = ex;
        end else begin
            ib.in_valid = v; ib.approx = ap; ib.exact = ex;
        end
    endtask

    task automatic set_start(input int sel, input logic s);
        if (sel == 0) a_start = s;
        else          b_start = s;
    endtask

    // Reference model: statistics of the whole pair list, saturated at the end
    // (all terms are non-negative, so clamping once equals clamping per add).
    task automatic model_calc(input int sel);
        longint lim, ed, sq;
        lim = (sel == 0) ? ((64'd1 << SUMWA) - 1) : ((64'd1 << SUMWB) - 1);
        exp_cnt = 0; exp_sad = 0; exp_max = 0; sq = 0;
        foreach (stim_ap[k]) begin
            ed = longint'(stim_ap[k]) - longint'(stim_ex[k]);
            if (ed < 0) ed = -ed;
            if (ed != 0) exp_cnt++;
            exp_sad += ed;
            if (ed > exp_max) exp_max = ed;
            sq += ed * ed;
        end
        if (exp_sad > lim) exp_sad = lim;
`ifdef SQERR_EN
        exp_sq = (sq > lim) ? lim : sq;
`else
        exp_sq = 0;
`endif
    endtask

    task automatic check_stats(input int sel, input string tag);
        model_calc(sel);
        check({tag, "_err_cnt"}, obs(sel, 3), exp_cnt);
        check({tag, "_sad"},     obs(sel, 4), exp_sad);
        check({tag, "_max_ed"},  obs(sel, 5), exp_max);
        check({tag, "_sq_sum"},  obs(sel, 6), exp_sq);
    endtask

    // mode 0: all pairs equal; mode 1: mix of equal, small, random, extreme errors
    task automatic fill_stim(input int n, input int mode);
        logic [W-1:0] a, e;
        int t;
        stim_ap.delete();
        stim_ex.delete();
        for (int k = 0; k < n; k++) begin
            a = r13();
            e = a;
            if (mode != 0) begin
                case ($urandom_range(3))
                    0: e = a;
                    1: begin
                        t = int'(a) + int'($urandom_range(14)) - 7;
                        if (t < 0) t = 0;
                        if (t > 8191) t = 8191;
                        e = W'(t);
                    end
                    2: e = r13();
                    default: begin
                        a = ($urandom_range(1) == 0) ? 13'd0 : 13'h1FFF;
                        e = ($urandom_range(1) == 0) ? 13'd0 : 13'h1FFF;
                    end
                endcase
            end
            stim_ap.push_back(a);
            stim_ex.push_back(e);
        end
    endtask

    // One complete run on instance sel with the current stim lists.
    // junk:      drive in_valid with garbage before start and during DRAIN
    // mid_start: pulse start together with the second presented pair
    task automatic do_run(input int sel, input int gap_pct, input bit junk,
                          input bit mid_start, input string tag);
        int i, guard, n;
        logic v;
        n = stim_ap.size();
        if (junk) begin
            for (int k = 0; k < 3; k++) begin
                set_in(sel, 1'b1, r13(), r13());
                @(posedge clk); #1;
            end
            check({tag, "_pre_ready"}, obs(sel, 0), 0);
        end
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        check({tag, "_start_ready"}, obs(sel, 0), 1);
        check({tag, "_start_busy"},  obs(sel, 1), 1);
        check({tag, "_start_done"},  obs(sel, 2), 0);
        check({tag, "_start_sad"},   obs(sel, 4), 0);
        i = 0;
        guard = 0;
        while (i < n && guard < 20000) begin
            v = ($urandom_range(99) >= gap_pct);
            if (v) set_in(sel, 1'b1, stim_ap[i], stim_ex[i]);
            else   set_in(sel, 1'b0, r13(), r13());
            set_start(sel, mid_start && (i == 1) && v);
            @(posedge clk); #1;
            if (v) i++;
            guard++;
        end
        set_start(sel, 1'b0);
        if (guard >= 20000) check({tag, "_accept_budget"}, i, n);
        set_in(sel, junk, r13(), r13());
        check({tag, "_last_ready"}, obs(sel, 0), 0);
        check({tag, "_last_busy"},  obs(sel, 1), 1);
        check({tag, "_last_done"},  obs(sel, 2), 0);
        @(posedge clk); #1;
        check({tag, "_drain_done"}, obs(sel, 2), 0);
        @(posedge clk); #1;
        set_in(sel, 1'b0, r13(), r13());
        check({tag, "_fin_done"},  obs(sel, 2), 1);
        check({tag, "_fin_busy"},  obs(sel, 1), 0);
        check({tag, "_fin_ready"}, obs(sel, 0), 0);
        check_stats(sel, tag);
        // done is a level: stats must hold while idle in DONE
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_hold_done"}, obs(sel, 2), 1);
        check_stats(sel, {tag, "_hold"});
    endtask

    task automatic load_scen2();
        stim_ap.delete(); stim_ex.delete();
        stim_ap.push_back(13'd10);   stim_ex.push_back(13'd12);
        stim_ap.push_back(13'd12);   stim_ex.push_back(13'd10);
        stim_ap.push_back(13'd0);    stim_ex.push_back(13'd8191);
        stim_ap.push_back(13'd5);    stim_ex.push_back(13'd5);
    endtask

    task automatic check_reset_all(input string tag);
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 7; w++) begin
                check($sformatf("%s_dut%0d_out%0d", tag, s, w), obs(s, w), 0);
            end
        end
    endtask

    initial begin
        set_in(0, 1'b0, '0, '0);
        set_in(1, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_all("reset");
        rst = 1'b0;

        // A: exhaustive-length run of equal words -> all stats zero
        fill_stim(NA, 0);
        do_run(0, 0, 1'b0, 1'b0, "a_equal");
        // A: mixed errors with gaps and junk outside RUN
        fill_stim(NA, 1);
        do_run(0, 20, 1'b1, 1'b0, "a_mixed");

        // B: directed pairs, back-to-back, then with gaps and junk
        load_scen2();
        do_run(1, 0, 1'b0, 1'b0, "b_scen2");
        check("b_scen2_const_err", obs(1, 3), 3);
        check("b_scen2_const_sad", obs(1, 4), 8195);
        check("b_scen2_const_max", obs(1, 5), 8191);
        do_run(1, 40, 1'b1, 1'b0, "b_scen3");

        // B: pipeline latency and reset mid-run
        set_start(1, 1'b1);
        @(posedge clk); #1;
        set_start(1, 1'b0);
        set_in(1, 1'b1, 13'd10, 13'd12);
        @(posedge clk); #1;
        set_in(1, 1'b0, '0, '0);
        check("lat_t0_sad", obs(1, 4), 0);
        @(posedge clk); #1;
        check("lat_t1_sad", obs(1, 4), 0);
        @(posedge clk); #1;
        check("lat_t2_sad", obs(1, 4), 2);
        check("lat_t2_err", obs(1, 3), 1);
        check("lat_t2_max", obs(1, 5), 2);
        set_in(1, 1'b1, 13'd12, 13'd10);
        @(posedge clk); #1;
        set_in(1, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("lat_2nd_sad", obs(1, 4), 4);
        check("lat_2nd_busy", obs(1, 1), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_all("midrst");
        load_scen2();
        do_run(1, 0, 1'b0, 1'b0, "b_after_rst");

        // B: saturation of sad at 2^14-1
        stim_ap.delete(); stim_ex.delete();
        for (int k = 0; k < NB; k++) begin
            stim_ap.push_back(13'h1FFF);
            stim_ex.push_back(13'd0);
        end
        do_run(1, 0, 1'b0, 1'b0, "b_sat");
        check("b_sat_const_sad", obs(1, 4), 16383);
        check("b_sat_const_err", obs(1, 3), NB);

        // B: start mid-RUN ignored; start from DONE clears (checked in do_run)
        fill_stim(NB, 1);
        do_run(1, 0, 1'b0, 1'b1, "b_midstart");
        for (int r = 0; r < 20; r++) begin
            fill_stim(NB, 1);
            do_run(1, 30, r[0], r[1], $sformatf("b_rand%0d", r));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
